// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and frame geometry.
package uart_pkg;

   // Transmit FSM states, one per segment of an 8N1 frame.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;
   localparam int IDX_W      = $clog2(DATA_BITS);

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module baud_counter #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic bit_end
);

   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_end = enable && (cnt_q == LAST);

   // Next count: restart wins, wrap on the bit end, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts a byte in IDLE and shifts it out LSB first.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   // The timer is held at zero in IDLE so each frame's phase starts at the accept edge.
   baud_counter #(.DIV(DIV)) u_baud (
      .clk     (clk),
      .reset   (reset),
      .restart (state_q == IDLE),
      .enable  (state_q != IDLE),
      .bit_end (bit_end)
   );

   // Next-state and output decode for the frame sequencer.
   // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start) begin
               state_d = START;
               tx_d    = 1'b0;
               shift_d = tx_data;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame state registers; reset aborts any frame in flight without a done pulse.
   // NOTE: the shift register is reset too, so a restarted link never exposes a stale byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV = 10 (CLK_FREQ 1000, BAUD 100).
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx, tx_busy, tx_done;

   int total = 0;
   int bad   = 0;

   // Stimulus hooks applied inside check_frame at given frame cycles (-100 = unused).
   int drop_at = -100;
   int poke_a  = -100;
   int poke_b  = -100;

   uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic obs, input logic exp, input string tag);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Line idle and no activity for n cycles.
   task automatic idle_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         chk(tx, 1'b1, {tag, "_tx"});
         chk(tx_busy, 1'b0, {tag, "_busy"});
         chk(tx_done, 1'b0, {tag, "_done"});
         tick();
      end
   endtask

   // Called just after the accept edge; checks ncyc frame cycles, and the done
   // cycle if the whole frame (100 cycles) was covered.
   task automatic check_frame(input logic [7:0] b, input int ncyc, input string tag);
      int   seg;
      logic exp_tx;
      for (int i = 0; i < ncyc; i++) begin
         seg = i / 10;
         if (seg == 0)      exp_tx = 1'b0;
         else if (seg == 9) exp_tx = 1'b1;
         else               exp_tx = b[seg-1];
         chk(tx, exp_tx, {tag, "_tx"});
         chk(tx_busy, 1'b1, {tag, "_busy"});
         chk(tx_done, 1'b0, {tag, "_done"});
         if (i == drop_at) start = 1'b0;
         if (i == poke_a || i == poke_b) begin
            start   = 1'b1;
            tx_data = 8'h55;
         end else if (i == poke_a + 1 || i == poke_b + 1) begin
            start = 1'b0;
         end
         tick();
      end
      if (ncyc == 100) begin
         chk(tx, 1'b1, {tag, "_end_tx"});
         chk(tx_busy, 1'b0, {tag, "_end_busy"});
         chk(tx_done, 1'b1, {tag, "_end_done"});
      end
   endtask

   initial begin
      // 1. Reset held for 3 cycles, then idle.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk(tx, 1'b1, "rst_tx");
         chk(tx_busy, 1'b0, "rst_busy");
         chk(tx_done, 1'b0, "rst_done");
      end
      reset = 1'b1;
      idle_check(20, "post_rst");

      // 2. Single one-cycle request with 0x30.
      start = 1'b1; tx_data = 8'h30;
      tick();
      start = 1'b0;
      check_frame(8'h30, 100, "single");
      tick();
      idle_check(20, "single_idle");

      // 3. Upstream pattern: start for 2 cycles, byte increments in the second.
      start = 1'b1; tx_data = 8'h30;
      tick();
      tx_data = 8'h31;
      drop_at = 0;
      check_frame(8'h30, 100, "up2");
      drop_at = -100;
      tick();
      idle_check(30, "up2_idle");

      // 4. Requests with 0x55 at cycles 30 and 60 of a 0x41 frame are ignored.
      start = 1'b1; tx_data = 8'h41;
      tick();
      start = 1'b0;
      poke_a = 30; poke_b = 60;
      check_frame(8'h41, 100, "busy_req");
      poke_a = -100; poke_b = -100;
      tick();
      idle_check(30, "busy_idle");

      // 5. Continuous start: 0x31 then 0x32, second accepted right after done.
      start = 1'b1; tx_data = 8'h31;
      tick();
      tx_data = 8'h32;
      check_frame(8'h31, 100, "cont1");
      tick();
      drop_at = 0;
      check_frame(8'h32, 100, "cont2");
      drop_at = -100;
      tick();
      idle_check(20, "cont_idle");

      // 6. Reset at cycle 45 of a 0xA5 frame, then a clean 0x3C frame.
      start = 1'b1; tx_data = 8'hA5;
      tick();
      start = 1'b0;
      check_frame(8'hA5, 45, "pre_abort");
      reset = 1'b0;
      #1;
      chk(tx, 1'b1, "abort_tx");
      chk(tx_busy, 1'b0, "abort_busy");
      chk(tx_done, 1'b0, "abort_done");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk(tx, 1'b1, "abort_hold_tx");
         chk(tx_busy, 1'b0, "abort_hold_busy");
         chk(tx_done, 1'b0, "abort_hold_done");
      end
      reset = 1'b1;
      idle_check(15, "abort_idle");
      start = 1'b1; tx_data = 8'h3C;
      tick();
      start = 1'b0;
      check_frame(8'h3C, 100, "after_abort");
      tick();
      idle_check(10, "final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
